// File: rtl/mouse_master_sm.sv
// PS/2 mouse master: drives the reset/enable handshake through the byte TX/RX pair,
// then assembles 3-byte stream packets into status/dX/dY with a one-cycle interrupt.
module mouse_master_sm #(
    parameter int POWERUP_CYCLES = 5_000_000,
    parameter int RESP_TIMEOUT   = 50_000_000,
    parameter int PKT_TIMEOUT    = 100_000
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic       SEND_INTERRUPT,
    output logic       INIT_DONE
);

    typedef enum logic [3:0] {
        S_WAIT, S_TXRST, S_TXRST_W, S_ACK1, S_SELF, S_ID,
        S_TXEN, S_TXEN_W, S_ACK2, S_B0, S_B1, S_B2, S_PKT
    } state_t;

    localparam logic [26:0] L_POWERUP_LAST = 27'(POWERUP_CYCLES - 1);
    localparam logic [26:0] L_RESP_LAST    = 27'(RESP_TIMEOUT - 1);
    localparam logic [26:0] L_PKT_LAST     = 27'(PKT_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [26:0] r_count;
    logic        r_send;
    logic [7:0]  r_byte_to_send;
    logic        r_read_enable;
    logic        r_interrupt;
    logic        r_init_done;
    logic [7:0]  r_status;
    logic [7:0]  r_dx;
    logic [7:0]  r_dy;
    logic [7:0]  r_sh_status;
    logic [7:0]  r_sh_dx;
    logic [7:0]  r_sh_dy;

    logic w_byte_ok;
    logic w_resp_to;
    logic w_pkt_to;

    assign w_byte_ok = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
    assign w_resp_to = (r_count == L_RESP_LAST);
    assign w_pkt_to  = (r_count == L_PKT_LAST);

    // A received byte always takes priority over a timeout landing on the same cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_WAIT:    if (r_count == L_POWERUP_LAST) w_next_state = S_TXRST;
            S_TXRST:   w_next_state = S_TXRST_W;
            S_TXRST_W: begin
                if (BYTE_SENT)      w_next_state = S_ACK1;
                else if (w_resp_to) w_next_state = S_WAIT;
            end
            S_ACK1: begin
                if (BYTE_READY)     w_next_state = (w_byte_ok && BYTE_READ == 8'hFA) ? S_SELF : S_WAIT;
                else if (w_resp_to) w_next_state = S_WAIT;
            end
            S_SELF: begin
                if (BYTE_READY)     w_next_state = (w_byte_ok && BYTE_READ == 8'hAA) ? S_ID : S_WAIT;
                else if (w_resp_to) w_next_state = S_WAIT;
            end
            S_ID: begin
                if (BYTE_READY)     w_next_state = (w_byte_ok && BYTE_READ == 8'h00) ? S_TXEN : S_WAIT;
                else if (w_resp_to) w_next_state = S_WAIT;
            end
            S_TXEN:    w_next_state = S_TXEN_W;
            S_TXEN_W: begin
                if (BYTE_SENT)      w_next_state = S_ACK2;
                else if (w_resp_to) w_next_state = S_WAIT;
            end
            S_ACK2: begin
                if (BYTE_READY)     w_next_state = (w_byte_ok && BYTE_READ == 8'hFA) ? S_B0 : S_WAIT;
                else if (w_resp_to) w_next_state = S_WAIT;
            end
            S_B0:      if (w_byte_ok && BYTE_READ[3]) w_next_state = S_B1;
            S_B1: begin
                if (BYTE_READY)     w_next_state = w_byte_ok ? S_B2 : S_B0;
                else if (w_pkt_to)  w_next_state = S_B0;
            end
            S_B2: begin
                if (BYTE_READY)     w_next_state = w_byte_ok ? S_PKT : S_B0;
                else if (w_pkt_to)  w_next_state = S_B0;
            end
            S_PKT:     w_next_state = S_B0;
            default:   w_next_state = S_WAIT;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state        <= S_WAIT;
            r_count        <= '0;
            r_send         <= 1'b0;
            r_byte_to_send <= 8'h00;
            r_read_enable  <= 1'b0;
            r_interrupt    <= 1'b0;
            r_init_done    <= 1'b0;
            r_status       <= 8'h00;
            r_dx           <= 8'h00;
            r_dy           <= 8'h00;
        end else begin
            r_state       <= w_next_state;
            r_count       <= (w_next_state != r_state) ? 27'd0 : r_count + 27'd1;
            r_send        <= (w_next_state == S_TXRST) || (w_next_state == S_TXEN);
            if (w_next_state == S_TXRST)     r_byte_to_send <= 8'hFF;
            else if (w_next_state == S_TXEN) r_byte_to_send <= 8'hF4;
            r_read_enable <= w_next_state inside {S_ACK1, S_SELF, S_ID, S_ACK2,
                                                  S_B0, S_B1, S_B2, S_PKT};
            r_init_done   <= w_next_state inside {S_B0, S_B1, S_B2, S_PKT};
            r_interrupt   <= (r_state == S_PKT);
            if (r_state == S_PKT) begin
                r_status <= r_sh_status;
                r_dx     <= r_sh_dx;
                r_dy     <= r_sh_dy;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_byte_ok) begin
            case (r_state)
                S_B0:    if (BYTE_READ[3]) r_sh_status <= BYTE_READ;
                S_B1:    r_sh_dx <= BYTE_READ;
                S_B2:    r_sh_dy <= BYTE_READ;
                default: ;
            endcase
        end
    end

    assign SEND_BYTE      = r_send;
    assign BYTE_TO_SEND   = r_byte_to_send;
    assign READ_ENABLE    = r_read_enable;
    assign SEND_INTERRUPT = r_interrupt;
    assign INIT_DONE      = r_init_done;
    assign MOUSE_STATUS   = r_status;
    assign MOUSE_DX       = r_dx;
    assign MOUSE_DY       = r_dy;

endmodule

// File: tb/tb_mouse_master_sm.sv
// Bench for mouse_master_sm: directed handshake/stream scenarios plus a reactive random mouse,
// all checked every cycle against a transaction-level model of the link.
module tb_mouse_master_sm;
    localparam int PU = 10;
    localparam int RT = 200;
    localparam int PT = 50;

    localparam int PH_IDLE   = 0;
    localparam int PH_SEND   = 1;
    localparam int PH_WSENT  = 2;
    localparam int PH_WREPLY = 3;
    localparam int PH_STREAM = 4;
    localparam int PH_PUB    = 5;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT = 1'b0;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ = 8'h00;
    logic [1:0] BYTE_ERROR_CODE = 2'b00;
    logic       BYTE_READY = 1'b0;
    logic [7:0] MOUSE_STATUS;
    logic [7:0] MOUSE_DX;
    logic [7:0] MOUSE_DY;
    logic       SEND_INTERRUPT;
    logic       INIT_DONE;

    always #5 CLK = ~CLK;

    mouse_master_sm #(.POWERUP_CYCLES(PU), .RESP_TIMEOUT(RT), .PKT_TIMEOUT(PT)) dut (
        .CLK(CLK), .RESET(RESET), .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND),
        .BYTE_SENT(BYTE_SENT), .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
        .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY),
        .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_DX(MOUSE_DX), .MOUSE_DY(MOUSE_DY),
        .SEND_INTERRUPT(SEND_INTERRUPT), .INIT_DONE(INIT_DONE)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Link model: progress through an expected-reply list, then collect packet bytes.
    int         m_phase = PH_IDLE;
    int         m_timer = 0;
    bit         m_live  = 1'b0;
    bit         m_int   = 1'b0;
    logic [7:0] m_cmd   = 8'h00;
    logic [7:0] m_st    = 8'h00;
    logic [7:0] m_dx    = 8'h00;
    logic [7:0] m_dy    = 8'h00;
    logic [7:0] m_expect[$];
    logic [7:0] m_pkt[$];

    always @(posedge CLK) begin : model
        int pph, pexp, ppkt;
        if (RESET) begin
            m_phase = PH_IDLE; m_timer = 0; m_cmd = 8'h00; m_int = 1'b0;
            m_st = 8'h00; m_dx = 8'h00; m_dy = 8'h00;
            m_pkt.delete(); m_expect.delete(); m_live = 1'b1;
        end else begin
            pph = m_phase; pexp = m_expect.size(); ppkt = m_pkt.size();
            m_int = (m_phase == PH_PUB);
            if (m_phase == PH_PUB) begin
                m_st = m_pkt[0]; m_dx = m_pkt[1]; m_dy = m_pkt[2];
            end
            case (m_phase)
                PH_IDLE: if (m_timer == PU - 1) begin
                    m_phase = PH_SEND; m_cmd = 8'hFF; m_expect = '{8'hFA, 8'hAA, 8'h00};
                end
                PH_SEND: m_phase = PH_WSENT;
                PH_WSENT: begin
                    if (BYTE_SENT) m_phase = PH_WREPLY;
                    else if (m_timer == RT - 1) m_phase = PH_IDLE;
                end
                PH_WREPLY: begin
                    if (BYTE_READY) begin
                        if (BYTE_READ == m_expect[0] && BYTE_ERROR_CODE == 2'b00) begin
                            void'(m_expect.pop_front());
                            if (m_expect.size() == 0) begin
                                if (m_cmd == 8'hFF) begin
                                    m_phase = PH_SEND; m_cmd = 8'hF4; m_expect = '{8'hFA};
                                end else begin
                                    m_phase = PH_STREAM; m_pkt.delete();
                                end
                            end
                        end else m_phase = PH_IDLE;
                    end else if (m_timer == RT - 1) m_phase = PH_IDLE;
                end
                PH_STREAM: begin
                    if (BYTE_READY) begin
                        if (BYTE_ERROR_CODE != 2'b00) m_pkt.delete();
                        else if (!(m_pkt.size() == 0 && !BYTE_READ[3])) begin
                            m_pkt.push_back(BYTE_READ);
                            if (m_pkt.size() == 3) m_phase = PH_PUB;
                        end
                    end else if (m_pkt.size() != 0 && m_timer == PT - 1) m_pkt.delete();
                end
                PH_PUB: begin
                    m_phase = PH_STREAM; m_pkt.delete();
                end
                default: m_phase = PH_IDLE;
            endcase
            if (m_phase != pph || m_expect.size() != pexp || m_pkt.size() != ppkt) m_timer = 0;
            else m_timer++;
        end
    end

    always @(negedge CLK) begin
        if (m_live) begin
            chk("send_byte", 8'(SEND_BYTE), 8'(m_phase == PH_SEND));
            chk("byte_to_send", BYTE_TO_SEND, m_cmd);
            chk("read_enable", 8'(READ_ENABLE),
                8'(m_phase == PH_WREPLY || m_phase == PH_STREAM || m_phase == PH_PUB));
            chk("init_done", 8'(INIT_DONE), 8'(m_phase == PH_STREAM || m_phase == PH_PUB));
            chk("interrupt", 8'(SEND_INTERRUPT), 8'(m_int));
            chk("status", MOUSE_STATUS, m_st);
            chk("dx", MOUSE_DX, m_dx);
            chk("dy", MOUSE_DY, m_dy);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic rx(input logic [7:0] b, input logic [1:0] e = 2'b00);
        BYTE_READ = b; BYTE_ERROR_CODE = e; BYTE_READY = 1'b1;
        tick();
        BYTE_READY = 1'b0; BYTE_ERROR_CODE = 2'b00;
    endtask

    task automatic txdone();
        BYTE_SENT = 1'b1;
        tick();
        BYTE_SENT = 1'b0;
    endtask

    task automatic wait_send(input logic [7:0] b, input int budget, output int cycles);
        cycles = 0;
        while (SEND_BYTE !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        if (SEND_BYTE !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL wait_send: no SEND_BYTE within %0d cycles, expected cmd %02h", budget, b);
        end else chk("cmd_value", BYTE_TO_SEND, b);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_send"}, 8'(SEND_BYTE), 8'h00);
        chk({tag, "_byte"}, BYTE_TO_SEND, 8'h00);
        chk({tag, "_rden"}, 8'(READ_ENABLE), 8'h00);
        chk({tag, "_int"}, 8'(SEND_INTERRUPT), 8'h00);
        chk({tag, "_init"}, 8'(INIT_DONE), 8'h00);
        chk({tag, "_status"}, MOUSE_STATUS, 8'h00);
        chk({tag, "_dx"}, MOUSE_DX, 8'h00);
        chk({tag, "_dy"}, MOUSE_DY, 8'h00);
    endtask

    initial begin
        int c;
        RESET = 1'b1;
        tick(3);
        chk_all_zero("reset");
        RESET = 1'b0;

        wait_send(8'hFF, 100, c);
        chk("powerup_cycles", 8'(c), 8'd10);
        tick();
        chk("send_pulse_width", 8'(SEND_BYTE), 8'h00);
        chk("rden_while_tx", 8'(READ_ENABLE), 8'h00);
        tick(2);
        txdone();
        chk("rden_ack1", 8'(READ_ENABLE), 8'h01);
        rx(8'hFA); tick(2); rx(8'hAA); rx(8'h00);
        wait_send(8'hF4, 5, c);
        chk("f4_immediate", 8'(c), 8'd0);
        tick();
        txdone();
        rx(8'hFA);
        chk("init_done", 8'(INIT_DONE), 8'h01);

        tick(3);
        rx(8'h09); tick(2); rx(8'h05); rx(8'hFB);
        chk("int_early", 8'(SEND_INTERRUPT), 8'h00);
        tick();
        chk("int_pulse", 8'(SEND_INTERRUPT), 8'h01);
        chk("pkt1_status", MOUSE_STATUS, 8'h09);
        chk("pkt1_dx", MOUSE_DX, 8'h05);
        chk("pkt1_dy", MOUSE_DY, 8'hFB);
        tick();
        chk("int_one_cycle", 8'(SEND_INTERRUPT), 8'h00);

        rx(8'h0A); rx(8'h01); rx(8'h33, 2'b01);
        tick(3);
        chk("err_dx_kept", MOUSE_DX, 8'h05);
        rx(8'h08); rx(8'h01); rx(8'h02);
        tick();
        chk("pkt2_status", MOUSE_STATUS, 8'h08);
        chk("pkt2_dy", MOUSE_DY, 8'h02);

        rx(8'h05); rx(8'h18); rx(8'h03); rx(8'h04);
        tick();
        chk("resync_status", MOUSE_STATUS, 8'h18);
        chk("resync_dx", MOUSE_DX, 8'h03);

        rx(8'h09); tick(60); rx(8'h0B); rx(8'h07); rx(8'h06);
        tick();
        chk("gap_status", MOUSE_STATUS, 8'h0B);
        chk("gap_dx", MOUSE_DX, 8'h07);
        chk("gap_dy", MOUSE_DY, 8'h06);

        rx(8'h08); rx(8'h11);
        RESET = 1'b1;
        tick();
        chk_all_zero("midreset");
        RESET = 1'b0;
        wait_send(8'hFF, 100, c);
        chk("restart_cycles", 8'(c), 8'd10);

        tick(2); txdone(); rx(8'hFE);
        wait_send(8'hFF, 100, c);
        chk("badack_cycles", 8'(c), 8'd10);

        tick();
        wait_send(8'hFF, 400, c);
        chk("sent_timeout_cycles", 8'(c), 8'd210);

        for (int i = 0; i < 12000; i++) begin
            BYTE_SENT = (m_phase == PH_WSENT && $urandom_range(0, 9) == 0) || ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 5) == 0) begin
                BYTE_READY = 1'b1;
                if (m_phase == PH_WREPLY && m_expect.size() > 0 && $urandom_range(0, 9) != 0)
                    BYTE_READ = m_expect[0];
                else
                    BYTE_READ = 8'($urandom);
                BYTE_ERROR_CODE = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end else begin
                BYTE_READY = 1'b0;
                BYTE_ERROR_CODE = 2'b00;
            end
            RESET = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 399) == 0) begin
                BYTE_READY = 1'b0; BYTE_SENT = 1'b0; RESET = 1'b0;
                tick($urandom_range(40, 260));
            end
            tick();
        end
        BYTE_READY = 1'b0; BYTE_SENT = 1'b0; RESET = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
